// File: rtl/admin_session.sv
// Operator session controller: password login with failure lockout, admin commands
// on the per-channel stock table, customer sales. Optional idle timeout: ADMIN_TIMEOUT_EN.
module admin_session #(
   parameter int             CHANNELS       = 8,
   parameter int             CH_W           = 3,
   parameter int             CNT_W          = 7,
   parameter int             CAP            = 99,
   parameter int             PW_W           = 5,
   parameter logic [PW_W-1:0] PASSWORD      = 5'b01011,
   parameter int             MAX_FAIL       = 3,
   parameter int             LOCK_CYCLES    = 1000,
   parameter int             TIMEOUT_CYCLES = 5000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PW_W-1:0]  pw_in_i,
   input  logic             login_i,
   input  logic             logout_i,
   input  logic             cmd_valid_i,
   input  logic [1:0]       cmd_i,
   input  logic [CH_W-1:0]  ch_i,
   input  logic [CNT_W-1:0] qty_i,
   input  logic             sell_valid_i,
   input  logic [CH_W-1:0]  sell_ch_i,
   output logic             en_o,
   output logic             locked_o,
   output logic [1:0]       fail_cnt_o,
   output logic             cmd_ack_o,
   output logic             cmd_err_o,
   output logic [CNT_W-1:0] rd_count_o,
   output logic             sell_ok_o,
   output logic             sell_rej_o
);
   typedef enum logic [1:0] {IDLE, ADMIN, LOCKED} state_t;
   localparam int LK_W = $clog2(LOCK_CYCLES + 1);

   state_t                         state_q, state_d;
   logic [1:0]                     fail_q, fail_d;
   logic [LK_W-1:0]                lock_q, lock_d;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]               rd_q, rd_d;
   logic                           ack_q, ack_d, err_q, err_d, sok_q, sok_d, srej_q, srej_d;
   logic [CNT_W:0]                 sum;
   logic                           ch_ok, sch_ok;
`ifdef ADMIN_TIMEOUT_EN
   localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TM_W-1:0]                tmo_q, tmo_d;
`endif

   assign ch_ok  = 32'(ch_i) < CHANNELS;
   assign sch_ok = 32'(sell_ch_i) < CHANNELS;
   assign sum    = {1'b0, cnt_q[ch_i]} + {1'b0, qty_i};

   always_comb begin
      state_d = state_q;
      fail_d  = fail_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      sok_d   = 1'b0;
      srej_d  = 1'b0;
`ifdef ADMIN_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE: if (login_i) begin
            if (pw_in_i == PASSWORD) begin
               state_d = ADMIN;
               fail_d  = 2'd0;
`ifdef ADMIN_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end else if (32'(fail_q) + 1 >= MAX_FAIL) begin
               state_d = LOCKED;
               lock_d  = LK_W'(LOCK_CYCLES - 1);
               fail_d  = 2'd0;
            end else if (fail_q != 2'd3) begin
               fail_d = fail_q + 2'd1;
            end
         end
         LOCKED: begin
            if (lock_q == '0) state_d = IDLE;
            else              lock_d  = lock_q - 1'b1;
         end
         ADMIN: begin
            if (logout_i) state_d = IDLE;
`ifdef ADMIN_TIMEOUT_EN
            else if (cmd_valid_i || login_i) tmo_d = '0;
            else if (32'(tmo_q) + 1 >= TIMEOUT_CYCLES) begin
               state_d = IDLE;
               tmo_d   = '0;
            end else tmo_d = tmo_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (cmd_valid_i) begin
         if (state_q == ADMIN && ch_ok) begin
            ack_d = 1'b1;
            case (cmd_i)
               2'b00: rd_d = cnt_q[ch_i];
               2'b01: begin
                  if (sum > (CNT_W+1)'(CAP)) begin
                     cnt_d[ch_i] = CNT_W'(CAP);
                     rd_d        = CNT_W'(CAP);
                     err_d       = 1'b1;
                  end else begin
                     cnt_d[ch_i] = sum[CNT_W-1:0];
                     rd_d        = sum[CNT_W-1:0];
                  end
               end
               2'b10: begin
                  cnt_d[ch_i] = '0;
                  rd_d        = '0;
               end
               default: begin
                  cnt_d = '0;
                  rd_d  = '0;
               end
            endcase
         end else err_d = 1'b1;
      end

      // Sales and commands never write the table together: one needs ADMIN, the other forbids it
      if (sell_valid_i) begin
         if (state_q != ADMIN && sch_ok && cnt_q[sell_ch_i] != '0) begin
            cnt_d[sell_ch_i] = cnt_q[sell_ch_i] - 1'b1;
            sok_d            = 1'b1;
         end else srej_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         fail_q  <= 2'd0;
         lock_q  <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         sok_q   <= 1'b0;
         srej_q  <= 1'b0;
`ifdef ADMIN_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         sok_q   <= sok_d;
         srej_q  <= srej_d;
`ifdef ADMIN_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign en_o       = state_q == ADMIN;
   assign locked_o   = state_q == LOCKED;
   assign fail_cnt_o = fail_q;
   assign cmd_ack_o  = ack_q;
   assign cmd_err_o  = err_q;
   assign rd_count_o = rd_q;
   assign sell_ok_o  = sok_q;
   assign sell_rej_o = srej_q;
endmodule

// File: tb/tb_admin_session.sv
// Scoreboard bench for admin_session: a behavioural model pushes expected outputs per
// driven cycle; they are popped and compared one cycle later.
module tb_admin_session;
   localparam logic [4:0] PW = 5'b01011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] pw_in = '0;
   logic       login = 1'b0, logout = 1'b0, cmd_valid = 1'b0, sell_valid = 1'b0;
   logic [1:0] cmd = '0;
   logic [2:0] ch = '0, sell_ch = '0;
   logic [6:0] qty = '0;
   logic       en, locked, cmd_ack, cmd_err, sell_ok, sell_rej;
   logic [1:0] fail_cnt;
   logic [6:0] rd_count;

   always #5 clk = ~clk;

   admin_session #(.TIMEOUT_CYCLES(20)) dut (
      .clk_i(clk), .rst_i(rst), .pw_in_i(pw_in), .login_i(login), .logout_i(logout),
      .cmd_valid_i(cmd_valid), .cmd_i(cmd), .ch_i(ch), .qty_i(qty),
      .sell_valid_i(sell_valid), .sell_ch_i(sell_ch),
      .en_o(en), .locked_o(locked), .fail_cnt_o(fail_cnt), .cmd_ack_o(cmd_ack),
      .cmd_err_o(cmd_err), .rd_count_o(rd_count), .sell_ok_o(sell_ok), .sell_rej_o(sell_rej)
   );

   typedef struct {
      logic       en, lk;
      logic [1:0] fc;
      logic       ack, err;
      logic [6:0] rd;
      logic       sok, srej;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0, n_bad = 0;
   int m_mode, m_fail, m_lk, m_idle, m_rd;
   int m_cnt[8];

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_fail = 0; m_lk = 0; m_idle = 0; m_rd = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      chk("rst_en", en, 0);       chk("rst_lock", locked, 0);
      chk("rst_fail", fail_cnt, 0); chk("rst_ack", cmd_ack, 0);
      chk("rst_err", cmd_err, 0); chk("rst_rd", rd_count, 0);
      chk("rst_sok", sell_ok, 0); chk("rst_srej", sell_rej, 0);
   endtask

   task automatic cyc(input logic li, input logic [4:0] pw, input logic lo,
                      input logic cv, input logic [1:0] c, input logic [2:0] chn,
                      input logic [6:0] q, input logic sv, input logic [2:0] sc);
      exp_t e;
      int   s;
      e = '{default: '0};
      if (cv) begin
         if (m_mode == 1) begin
            e.ack = 1'b1;
            case (c)
               2'd0: m_rd = m_cnt[chn];
               2'd1: begin
                  s = m_cnt[chn] + int'(q);
                  if (s > 99) begin s = 99; e.err = 1'b1; end
                  m_cnt[chn] = s; m_rd = s;
               end
               2'd2: begin m_cnt[chn] = 0; m_rd = 0; end
               default: begin foreach (m_cnt[i]) m_cnt[i] = 0; m_rd = 0; end
            endcase
         end else e.err = 1'b1;
      end
      if (sv) begin
         if (m_mode != 1 && m_cnt[sc] > 0) begin m_cnt[sc]--; e.sok = 1'b1; end
         else e.srej = 1'b1;
      end
      case (m_mode)
         0: if (li) begin
            if (pw == PW) begin m_mode = 1; m_fail = 0; m_idle = 0; end
            else begin
               m_fail++;
               if (m_fail == 3) begin m_mode = 2; m_lk = 1000; m_fail = 0; end
            end
         end
         1: if (lo) m_mode = 0;
            else if (cv || li) m_idle = 0;
            else begin
               m_idle++;
`ifdef ADMIN_TIMEOUT_EN
               if (m_idle == 20) m_mode = 0;
`endif
            end
         default: begin m_lk--; if (m_lk == 0) m_mode = 0; end
      endcase
      e.en = (m_mode == 1); e.lk = (m_mode == 2); e.fc = 2'(m_fail); e.rd = 7'(m_rd);

      @(negedge clk);
      login = li; pw_in = pw; logout = lo; cmd_valid = cv; cmd = c; ch = chn;
      qty = q; sell_valid = sv; sell_ch = sc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      login = 0; logout = 0; cmd_valid = 0; sell_valid = 0;
      e = sb.pop_front();
      chk("en", en, e.en);           chk("locked", locked, e.lk);
      chk("fail_cnt", fail_cnt, e.fc); chk("cmd_ack", cmd_ack, e.ack);
      chk("cmd_err", cmd_err, e.err); chk("rd_count", rd_count, e.rd);
      chk("sell_ok", sell_ok, e.sok); chk("sell_rej", sell_rej, e.srej);
   endtask

   task automatic nop(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic admin(input logic [1:0] c, input logic [2:0] chn, input logic [6:0] q);
      cyc(0, 0, 0, 1, c, chn, q, 0, 0);
   endtask
   task automatic sell(input logic [2:0] sc); cyc(0, 0, 0, 0, 0, 0, 0, 1, sc); endtask
   task automatic log_in(input logic [4:0] pw); cyc(1, pw, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      int nlk;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      log_in(PW);                       // en=1, fail_cnt=0
      admin(2'd1, 3'd2, 7'd60);         // rd 60, ack
      admin(2'd1, 3'd2, 7'd60);         // clipped 99, ack+err
      admin(2'd0, 3'd2, 7'd0);          // query 99
      admin(2'd1, 3'd5, 7'd3);
      admin(2'd2, 3'd5, 7'd0);          // clear channel
      admin(2'd0, 3'd5, 7'd0);
      admin(2'd2, 3'd2, 7'd0);
      admin(2'd1, 3'd2, 7'd2);
      admin(2'd1, 3'd7, 7'd50);
      sell(3'd7);                       // refused in ADMIN
      cyc(0, 0, 1, 1, 2'd0, 3'd7, 0, 0, 0); // command with logout: executes, en drops
      admin(2'd0, 3'd7, 7'd0);          // outside ADMIN -> err only
      sell(3'd2); sell(3'd2); sell(3'd2); // ok, ok, rej
      sell(3'd7);

      log_in(5'b00000); log_in(5'b00000);
      log_in(5'b00000);                 // enters lockout
      nlk = int'(locked);
      for (int i = 0; i < 1010; i++) begin
         if (i == 5)       sell(3'd7);  // sales still served while locked
         else if (i == 10) log_in(PW);  // ignored
         else if (i == 12) log_in(5'b00001);
         else              nop();
         if (locked) nlk++;
      end
      chk("lock_len", nlk, 1000);

      log_in(PW);
      admin(2'd1, 3'd0, 7'd9);
      cyc(0, 0, 0, 1, 2'd3, 3'd0, 0, 1, 3'd7); // clear all + sale -> sell_rej
      for (int c = 0; c < 8; c++) admin(2'd0, 3'(c), 7'd0);
      cyc(1, PW, 1, 0, 0, 0, 0, 0, 0);  // login+logout: logout wins

      log_in(PW);
      repeat (30) nop();                // timeout only when the macro is set
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

      log_in(PW);
      admin(2'd1, 3'd4, 7'd11);
      do_reset();                       // mid-session reset
      admin(2'd0, 3'd4, 7'd0);
      sell(3'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
